// File: rtl/mem_io_responder.sv
// Zero-wait-state responder for the processor memory bus: on-chip data RAM plus an
// I/O page with LED register, synchronised switches, free-running cycle counter and TX byte FIFO.
module mem_io_responder #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [63:0] IO_BASE    = 64'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [63:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [4:0] OFF_LED    = 5'd0;
  localparam logic [4:0] OFF_SWITCH = 5'd1;
  localparam logic [4:0] OFF_CYCLE  = 5'd2;
  localparam logic [4:0] OFF_TXDATA = 5'd3;
  localparam logic [4:0] OFF_STATUS = 5'd4;

  logic [63:0]       ram_q [RAM_WORDS];
  logic [7:0]        fifo_q [FIFO_DEPTH];

  logic [63:0]       led_q, led_d;
  logic [63:0]       cycle_q, cycle_d;
  logic [15:0]       sw_meta_q, sw_meta_d;
  logic [15:0]       sw_sync_q, sw_sync_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              io_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [4:0]        io_off;
  logic              wr_en;
  logic              ram_we;
  logic              io_we;
  logic              pop;
  logic              push_req;
  logic              push;
  logic [63:0]       io_rdata;
  logic [63:0]       rdata;
  logic              unused_addr;

  assign unused_addr = ^address;

  always_comb begin
    io_sel   = (address[63:16] == IO_BASE[63:16]);
    ram_idx  = address[3 +: RAM_AW];
    io_off   = address[7:3];
    // Accesses presented during the reset cycle are dropped.
    wr_en    = write && !reset;
    ram_we   = wr_en && !io_sel;
    io_we    = wr_en && io_sel;
    pop      = tx_valid && tx_ready;
    push_req = io_we && (io_off == OFF_TXDATA);
    push     = push_req && ((count_q != FIFO_FULL) || pop);

    led_d = led_q;
    if (io_we && (io_off == OFF_LED)) led_d = data;

    cycle_d = cycle_q + 64'd1;
    if (io_we && (io_off == OFF_CYCLE)) cycle_d = data + 64'd1;

    sw_meta_d = switches;
    sw_sync_d = sw_meta_q;

    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q;
    if (io_we && (io_off == OFF_STATUS)) ovf_d = 1'b0;
    if (push_req && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= '0;
      cycle_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      cycle_q   <= cycle_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays keep their contents through reset.
  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_idx] <= data;
    if (push) fifo_q[wr_ptr_q] <= data[7:0];
  end

  always_comb begin
    io_rdata = '0;
    case (io_off)
      OFF_LED:    io_rdata = led_q;
      OFF_SWITCH: io_rdata = {48'b0, sw_sync_q};
      OFF_CYCLE:  io_rdata = cycle_q;
      OFF_STATUS: begin
        io_rdata[8 +: CNT_W] = count_q;
        io_rdata[2]          = ovf_q;
        io_rdata[1]          = (count_q == FIFO_FULL);
        io_rdata[0]          = (count_q == '0);
      end
      default:    io_rdata = '0;
    endcase
    rdata = io_sel ? io_rdata : ram_q[ram_idx];
  end

  assign data     = (read && !write) ? rdata : 64'bz;
  assign leds     = led_q[15:0];
  assign tx_valid = (count_q != '0);
  assign tx_data  = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: table-driven bus vectors, hand sequences for FIFO,
// cycle counter and switch sync, and a byte scoreboard on the TX port.
module tb_mem_io_responder;

  localparam logic [63:0] IO = 64'hFFFF_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [63:0] address;
  logic [15:0] switches;
  logic [15:0] leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  wire  [63:0] data;
  logic        tb_oe;
  logic [63:0] tb_dout;

  assign data = tb_oe ? tb_dout : 64'bz;

  always #5 clock = ~clock;

  mem_io_responder dut (
    .clock    (clock),
    .reset    (reset),
    .data     (data),
    .address  (address),
    .read     (read),
    .write    (write),
    .switches (switches),
    .leds     (leds),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  int         n_pops   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] last_pop;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wd;
    logic        chk;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle. The bench drives the bus whenever the DUT must not, so an
  // illegal DUT drive shows up as a corrupted value on data.
  task automatic bus_cycle(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wd, input logic chk, input logic [63:0] exp,
                           input string name);
    logic pop;
    read    = rd;
    write   = wr;
    address = addr;
    tb_dout = wd;
    tb_oe   = !(rd && !wr);
    @(negedge clock);
    if (chk) check(name, data, exp);
    if (!reset) check("tx_valid", {63'b0, tx_valid}, {63'b0, sb_q.size() != 0});
    pop = tx_ready && (sb_q.size() != 0) && !reset;
    if (pop) begin
      check("tx_data", {56'b0, tx_data}, {56'b0, sb_q[0]});
      last_pop = tx_data;
      n_pops++;
    end
    if (reset) begin
      sb_q.delete();
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (wr && (addr[63:16] == IO[63:16]) && (addr[7:3] == 5'd3) && (sb_q.size() < 16))
        sb_q.push_back(wd[7:0]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 64'h0, "idle");
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) break;
      idle();
    end
    check("drain_done", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 64'h48, 64'h1111_2222_3333_4444, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 64'h40, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 1'b0, 64'h40, 64'h0, 1'b1, 64'hDEAD_BEEF_0123_4567};
    vecs[3]  = '{1'b1, 1'b0, 64'h48, 64'h0, 1'b1, 64'h1111_2222_3333_4444};
    vecs[4]  = '{1'b1, 1'b1, 64'h40, 64'h0BAD_F00D_CAFE_0001, 1'b1, 64'h0BAD_F00D_CAFE_0001};
    vecs[5]  = '{1'b1, 1'b0, 64'h40, 64'h0, 1'b1, 64'h0BAD_F00D_CAFE_0001};
    vecs[6]  = '{1'b0, 1'b0, 64'h48, 64'h5A5A_A5A5_0F0F_F0F0, 1'b1, 64'h5A5A_A5A5_0F0F_F0F0};
    vecs[7]  = '{1'b0, 1'b1, IO, 64'h5555_0000_0000_1234, 1'b0, 64'h0};
    vecs[8]  = '{1'b1, 1'b0, IO, 64'h0, 1'b1, 64'h5555_0000_0000_1234};
    vecs[9]  = '{1'b0, 1'b1, IO + 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
    vecs[10] = '{1'b1, 1'b0, IO + 64'h80, 64'h0, 1'b1, 64'h0};
    vecs[11] = '{1'b1, 1'b0, IO + 64'h18, 64'h0, 1'b1, 64'h0};
    vecs[12] = '{1'b0, 1'b1, 64'h0, 64'h7777, 1'b0, 64'h0};
    vecs[13] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_0000, 64'h0, 1'b1, 64'h7777};
    vecs[14] = '{1'b1, 1'b0, 64'h0001_0040, 64'h0, 1'b1, 64'h0BAD_F00D_CAFE_0001};
    vecs[15] = '{1'b1, 1'b0, IO, 64'h0, 1'b1, 64'h5555_0000_0000_1234};

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0;
    tb_oe = 1'b1; tb_dout = '0; switches = '0; tx_ready = 1'b0;
    @(posedge clock);
    #1;
    idle();
    idle();
    reset = 1'b0;
    check("leds_rst", {48'b0, leds}, 64'h0);
    check("tx_valid_rst", {63'b0, tx_valid}, 64'h0);
    bus_cycle(1'b1, 1'b0, IO + 64'h20, 64'h0, 1'b1, 64'h1, "status_rst");
    bus_cycle(1'b1, 1'b0, IO, 64'h0, 1'b1, 64'h0, "led_rst");

    for (int i = 0; i < 16; i++)
      bus_cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].chk, vecs[i].exp,
                $sformatf("vec%0d", i));
    check("leds_1234", {48'b0, leds}, 64'h1234);

    // switch synchroniser latency
    switches = 16'h00A5;
    bus_cycle(1'b1, 1'b0, IO + 64'h08, 64'h0, 1'b1, 64'h0, "sw_c0");
    bus_cycle(1'b1, 1'b0, IO + 64'h08, 64'h0, 1'b1, 64'h0, "sw_c1");
    bus_cycle(1'b1, 1'b0, IO + 64'h08, 64'h0, 1'b1, 64'h00A5, "sw_c2");

    // cycle counter after reset, then wrap on load
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("leds_rst2", {48'b0, leds}, 64'h0);
    bus_cycle(1'b1, 1'b0, IO + 64'h10, 64'h0, 1'b1, 64'h0, "cyc1");
    idle();
    idle();
    bus_cycle(1'b1, 1'b0, IO + 64'h10, 64'h0, 1'b1, 64'h3, "cyc4");
    bus_cycle(1'b0, 1'b1, IO + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, "cyc_wr");
    bus_cycle(1'b1, 1'b0, IO + 64'h10, 64'h0, 1'b1, 64'h0, "cyc_wrap");
    bus_cycle(1'b1, 1'b0, IO + 64'h10, 64'h0, 1'b1, 64'h1, "cyc_wrap1");
    bus_cycle(1'b1, 1'b0, 64'h40, 64'h0, 1'b1, 64'h0BAD_F00D_CAFE_0001, "ram_after_rst");

    // FIFO overflow then drain
    tx_ready = 1'b0;
    for (int i = 1; i <= 17; i++)
      bus_cycle(1'b0, 1'b1, IO + 64'h18, 64'(i), 1'b0, 64'h0, "push");
    bus_cycle(1'b1, 1'b0, IO + 64'h20, 64'h0, 1'b1, 64'h1006, "status_full_ovf");
    check("head_01", {56'b0, tx_data}, 64'h01);
    tx_ready = 1'b1;
    n_pops = 0;
    drain();
    check("pops_16", 64'(n_pops), 64'd16);
    check("last_10", {56'b0, last_pop}, 64'h10);
    check("tx_valid_drained", {63'b0, tx_valid}, 64'h0);
    bus_cycle(1'b1, 1'b0, IO + 64'h20, 64'h0, 1'b1, 64'h5, "status_ovf_sticky");
    bus_cycle(1'b0, 1'b1, IO + 64'h20, 64'h0, 1'b0, 64'h0, "status_clr");
    bus_cycle(1'b1, 1'b0, IO + 64'h20, 64'h0, 1'b1, 64'h1, "status_cleared");

    // push and pop on the same cycle while full
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      bus_cycle(1'b0, 1'b1, IO + 64'h18, 64'h21 + 64'(i), 1'b0, 64'h0, "push");
    tx_ready = 1'b1;
    n_pops = 0;
    bus_cycle(1'b0, 1'b1, IO + 64'h18, 64'hAA, 1'b0, 64'h0, "push_pop");
    tx_ready = 1'b0;
    bus_cycle(1'b1, 1'b0, IO + 64'h20, 64'h0, 1'b1, 64'h1002, "status_full_no_ovf");
    tx_ready = 1'b1;
    drain();
    check("pops_17", 64'(n_pops), 64'd17);
    check("last_aa", {56'b0, last_pop}, 64'hAA);

    // reset discards queued bytes
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      bus_cycle(1'b0, 1'b1, IO + 64'h18, 64'h61 + 64'(i), 1'b0, 64'h0, "push");
    check("tx_valid_3q", {63'b0, tx_valid}, 64'h1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("tx_valid_after_rst", {63'b0, tx_valid}, 64'h0);
    bus_cycle(1'b1, 1'b0, IO + 64'h20, 64'h0, 1'b1, 64'h1, "status_after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
